// File: rtl/vga_pixel_engine.sv
// Avalon-MM pixel writer: buffers pixel writes in a FIFO, clips them to the screen, and adds a
// hardware rectangle fill. Output is one registered plot per cycle toward the VGA adapter.
module vga_pixel_engine #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic                waitrequest,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int PW = X_W + Y_W + COLOUR_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count, wait_cnt, pend;
  logic                fifo_full, fifo_empty, push, pop, fill_step;
  logic [X_W-1:0]      x0, fx, x_end;
  logic [Y_W-1:0]      y0, fy, y_end;
  logic [COLOUR_W-1:0] fill_c;
  logic [15:0]         drop_cnt;

  logic [COLOUR_W-1:0] wd_c;
  logic [X_W-1:0]      wd_x;
  logic [Y_W-1:0]      wd_y;
  logic [X_W:0]        x_sum, x_end_c;
  logic [Y_W:0]        y_sum, y_end_c;
  logic                wr_acc, in_bounds, origin_ok, fill_req, fill_go, drop_inc, busy;
  logic [31:0]         rd_origin, rd_status;

  assign wd_c = writedata[COLOUR_W-1:0];
  assign wd_x = writedata[COLOUR_W +: X_W];
  assign wd_y = writedata[COLOUR_W+X_W +: Y_W];

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign waitrequest = write & (((address == 4'd0) & fifo_full) |
                                ((address == 4'd2) & (state_q != S_IDLE)));
  assign wr_acc = write & ~waitrequest;

  assign in_bounds = ({1'b0, wd_x} < H_LIM) && ({1'b0, wd_y} < V_LIM);
  assign origin_ok = ({1'b0, x0} < H_LIM) && ({1'b0, y0} < V_LIM);
  assign push      = wr_acc && (address == 4'd0) && in_bounds;
  assign fill_req  = wr_acc && (address == 4'd2);
  assign fill_go   = fill_req && origin_ok && (wd_x != '0) && (wd_y != '0);
  assign drop_inc  = (wr_acc && (address == 4'd0) && !in_bounds) || (fill_req && !origin_ok);

  // Extra bit keeps the end coordinate from wrapping before it is clipped to the screen edge.
  assign x_sum   = {1'b0, x0} + {1'b0, wd_x} - (X_W+1)'(1);
  assign y_sum   = {1'b0, y0} + {1'b0, wd_y} - (Y_W+1)'(1);
  assign x_end_c = (x_sum > H_LIM - (X_W+1)'(1)) ? H_LIM - (X_W+1)'(1) : x_sum;
  assign y_end_c = (y_sum > V_LIM - (Y_W+1)'(1)) ? V_LIM - (Y_W+1)'(1) : y_sum;

  assign busy = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    rd_origin = '0;
    rd_origin[X_W-1:0]  = x0;
    rd_origin[16 +: Y_W] = y0;
    rd_status = {busy, 7'b0, 8'(fifo_count), drop_cnt};
  end

  // wait_cnt tracks how many queued pixels predate the fill; later pushes stay behind it.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    fill_step = 1'b0;
    pend      = '0;
    case (state_q)
      S_IDLE: begin
        pop  = !fifo_empty;
        pend = fifo_count - CW'(pop);
        if (fill_go) state_d = (pend != '0) ? S_WAIT : S_FILL;
      end
      S_WAIT: begin
        pop = !fifo_empty;
        if (wait_cnt <= CW'(1)) state_d = S_FILL;
      end
      S_FILL: begin
        fill_step = 1'b1;
        if (fx == x_end && fy == y_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wd_y, wd_x, wd_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wait_cnt   <= '0;
      x0         <= '0;
      y0         <= '0;
      fx         <= '0;
      fy         <= '0;
      x_end      <= '0;
      y_end      <= '0;
      fill_c     <= '0;
      drop_cnt   <= '0;
      readdata   <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      vga_plot <= pop | fill_step;
      if (pop)            {vga_y, vga_x, vga_colour} <= fifo_mem[rd_ptr];
      else if (fill_step) {vga_y, vga_x, vga_colour} <= {fy, fx, fill_c};

      if (fill_go) begin
        fx       <= x0;
        fy       <= y0;
        x_end    <= x_end_c[X_W-1:0];
        y_end    <= y_end_c[Y_W-1:0];
        fill_c   <= wd_c;
        wait_cnt <= pend;
      end else if (state_q == S_WAIT && pop) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (fill_step) begin
        if (fx == x_end) begin
          fx <= x0;
          fy <= fy + Y_W'(1);
        end else begin
          fx <= fx + X_W'(1);
        end
      end

      if (wr_acc && address == 4'd1) begin
        x0 <= writedata[X_W-1:0];
        y0 <= writedata[16 +: Y_W];
      end

      if (wr_acc && address == 4'd3)            drop_cnt <= '0;
      else if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      if (read) begin
        case (address)
          4'd1:    readdata <= rd_origin;
          4'd3:    readdata <= rd_status;
          default: readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Directed bench for vga_pixel_engine: expected plots go into a queue when stimulus is driven
// and a negedge monitor pops and compares them as vga_plot pulses.
module tb_vga_pixel_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [7:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  vga_pixel_engine dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(input int x, input int y, input int c);
    logic [31:0] w;
    w = '0;
    w[7:0]   = 8'(c);
    w[15:8]  = 8'(x);
    w[22:16] = 7'(y);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && vga_plot) begin
      if (exp_q.size() == 0) chk("unexpected_plot", {9'b0, vga_y, vga_x, vga_colour}, 32'hFFFF_FFFF);
      else chk("plot", {9'b0, vga_y, vga_x, vga_colour}, exp_q.pop_front());
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    #1;
    n = 0;
    while (waitrequest && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) chk("write_timeout", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_xyc", {9'b0, vga_y, vga_x, vga_colour}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_waitreq", 32'(waitrequest), 32'd0);
    @(negedge clk) reset = 1'b0;

    // 1: single pixel, plot appears after the second edge
    exp_q.push_back(pix(10, 20, 128));
    wr(4'd0, pix(10, 20, 128));
    chk("t1_plot_not_yet", 32'(vga_plot), 32'd0);
    @(posedge clk); #1;
    chk("t1_plot_now", 32'(vga_plot), 32'd1);
    wait_drain();

    // 2: out-of-bounds pixel dropped and counted, then counter cleared
    wr(4'd0, pix(200, 150, 255));
    repeat (4) @(posedge clk);
    rd_reg(4'd3, rd);
    chk("t2_status_drop", rd, 32'h0000_0001);
    wr(4'd3, 32'd0);
    rd_reg(4'd3, rd);
    chk("t2_status_clr", rd, 32'h0000_0000);

    // 3: long fill holds the drain; ninth pixel write stalls on a full FIFO
    wr(4'd1, 32'd0);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 20; x++) exp_q.push_back(pix(x, y, 1));
    wr(4'd2, pix(20, 2, 1));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pix(i, 50, i + 10));
      wr(4'd0, pix(i, 50, i + 10));
    end
    rd_reg(4'd3, rd);
    chk("t3_status_full", rd, 32'h8008_0000);
    exp_q.push_back(pix(8, 50, 18));
    @(negedge clk);
    address = 4'd0; writedata = pix(8, 50, 18); write = 1'b1;
    #1;
    chk("t3_wr9_stall", 32'(waitrequest), 32'd1);
    n = 0;
    while (waitrequest && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("t3_wr9_release", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    write = 1'b0;
    wait_drain();

    // 4: fill clipped at the bottom-right corner
    wr(4'd1, (32'd118 << 16) | 32'd158);
    exp_q.push_back(pix(158, 118, 7));
    exp_q.push_back(pix(159, 118, 7));
    exp_q.push_back(pix(158, 119, 7));
    exp_q.push_back(pix(159, 119, 7));
    wr(4'd2, pix(4, 4, 7));
    wait_drain();

    // 5: ordering of queued pixel, fill and pixel written during fill
    wr(4'd1, (32'd40 << 16) | 32'd30);
    rd_reg(4'd1, rd);
    chk("t5_origin_rd", rd, (32'd40 << 16) | 32'd30);
    rd_reg(4'd5, rd);
    chk("t5_unmapped_rd", rd, 32'd0);
    exp_q.push_back(pix(5, 5, 9));
    exp_q.push_back(pix(30, 40, 3));
    exp_q.push_back(pix(31, 40, 3));
    exp_q.push_back(pix(1, 2, 4));
    wr(4'd0, pix(5, 5, 9));
    wr(4'd2, pix(2, 1, 3));
    wr(4'd0, pix(1, 2, 4));
    wait_drain();

    // 6: reset in the middle of a 10x10 fill
    wr(4'd1, 32'd0);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++) exp_q.push_back(pix(x, y, 2));
    wr(4'd2, pix(10, 10, 2));
    n = 0;
    while (exp_q.size() > 80 && n < 500) begin
      @(posedge clk); #2; n++;
    end
    chk("t6_reached_20", 32'(exp_q.size() <= 80), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_plot_off", 32'(vga_plot), 32'd0);
    chk("t6_xyc_zero", {9'b0, vga_y, vga_x, vga_colour}, 32'd0);
    chk("t6_readdata_zero", readdata, 32'd0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    rd_reg(4'd3, rd);
    chk("t6_status_zero", rd, 32'd0);
    rd_reg(4'd1, rd);
    chk("t6_origin_zero", rd, 32'd0);

    repeat (10) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
